rd4_pipe_adder: RTL and testbench

- Parametrised, pipelined radix-4 adder/subtractor for the systolic array's partial-sum accumulation path.
- Operands are split into 2-bit radix-4 digits; each pipeline stage resolves DIGITS_PER_STAGE digits and forwards its carry to the next stage.
- Operand words pass through a valid/ready handshake with global stall.
- Adds subtract mode, signed/unsigned overflow detection and backpressure; the single-digit cell has none of these.

---
 rtl/rd4_pkg.sv | 24 ++
 rtl/rd4_digit.sv | 22 ++
 rtl/rd4_pipe_adder.sv | 131 +++++++++++++
 tb/tb_rd4_pipe_adder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd4_pkg.sv
// rd4_pkg: shared constants, stage-depth helper and per-stage control record
// for the pipelined radix-4 adder/subtractor.
package rd4_pkg;

  // Width of one radix-4 digit in bits
  localparam int RD4_DIGIT_W = 2;

  // Control half of a pipeline stage record. The data half (partial sum with
  // unresolved A digits above it, and effective B) depends on WIDTH, so the
  // top module wraps this struct together with those vectors.
  typedef struct packed {
    logic valid;
    logic sub;
    logic is_signed;
    logic carry;
    logic ovf;
  } rd4_ctrl_t;

  // Pipeline depth: one stage per group of digits_per_stage radix-4 digits
  function automatic int rd4_stages(input int width, input int digits_per_stage);
    return width / (RD4_DIGIT_W * digits_per_stage);
  endfunction

endpackage

// File: rtl/rd4_digit.sv
// rd4_digit: combinational single radix-4 digit adder (2-bit a + b + cin).
module rd4_digit
  import rd4_pkg::*;
(
  input  logic [RD4_DIGIT_W-1:0] a,
  input  logic [RD4_DIGIT_W-1:0] b,
  input  logic                   cin,
  output logic [RD4_DIGIT_W-1:0] sum,
  output logic                   cout
);

  logic [RD4_DIGIT_W:0] total;

  // Three-input add; the extra top bit is the carry into the next digit
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{RD4_DIGIT_W{1'b0}}, cin};
  end

  assign sum  = total[RD4_DIGIT_W-1:0];
  assign cout = total[RD4_DIGIT_W];

endmodule

// File: rtl/rd4_pipe_adder.sv
// rd4_pipe_adder: pipelined radix-4 adder/subtractor with valid/ready
// handshake and global stall. Each stage resolves DIGITS_PER_STAGE digits.
// Optional macro RD4_SAT_EN: clamp the result on overflow instead of wrapping.
module rd4_pipe_adder
  import rd4_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int DIGITS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES  = rd4_stages(WIDTH, DIGITS_PER_STAGE);
  localparam int GROUP_W = RD4_DIGIT_W * DIGITS_PER_STAGE;

  // acc holds resolved sum bits below the current group and still-unresolved
  // A digits above it; opb is B after the subtract inversion.
  typedef struct packed {
    rd4_ctrl_t        ctrl;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opb;
  } stage_t;

  stage_t stage_q [STAGES];
  stage_t stage_d [STAGES];
  logic   adv;

  // The whole pipe moves only when the output slot is empty or being drained
  assign adv      = ~stage_q[STAGES-1].ctrl.valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t                    in_rec;
    stage_t                    nxt;
    logic [GROUP_W-1:0]        grp_sum;
    logic [DIGITS_PER_STAGE:0] chain;

    if (k == 0) begin : g_src
      // Stage 0 reads the ports; subtract inverts B and forces the carry-in
      always_comb begin
        in_rec                = '0;
        in_rec.ctrl.valid     = in_valid;
        in_rec.ctrl.sub       = sub;
        in_rec.ctrl.is_signed = is_signed;
        in_rec.ctrl.carry     = sub | cin;
        in_rec.acc            = a;
        in_rec.opb            = sub ? ~b : b;
      end
    end else begin : g_link
      assign in_rec = stage_q[k-1];
    end

    assign chain[0] = in_rec.ctrl.carry;

    for (genvar d = 0; d < DIGITS_PER_STAGE; d++) begin : g_digit
      rd4_digit u_digit (
        .a    (in_rec.acc[k*GROUP_W + d*RD4_DIGIT_W +: RD4_DIGIT_W]),
        .b    (in_rec.opb[k*GROUP_W + d*RD4_DIGIT_W +: RD4_DIGIT_W]),
        .cin  (chain[d]),
        .sum  (grp_sum[d*RD4_DIGIT_W +: RD4_DIGIT_W]),
        .cout (chain[d+1])
      );
    end

    // Replace digit group k with its sum; the last stage also decides overflow
    always_comb begin
      nxt                             = in_rec;
      nxt.acc[k*GROUP_W +: GROUP_W]   = grp_sum;
      nxt.ctrl.carry                  = chain[DIGITS_PER_STAGE];
      nxt.ctrl.ovf                    = 1'b0;
      if (k == STAGES - 1) begin
        if (in_rec.ctrl.is_signed) begin
          nxt.ctrl.ovf = (in_rec.acc[WIDTH-1] == in_rec.opb[WIDTH-1]) &&
                         (grp_sum[GROUP_W-1] != in_rec.acc[WIDTH-1]);
        end else begin
          nxt.ctrl.ovf = in_rec.ctrl.sub ? ~chain[DIGITS_PER_STAGE]
                                         :  chain[DIGITS_PER_STAGE];
        end
`ifdef RD4_SAT_EN
        if (nxt.ctrl.ovf) begin
          if (in_rec.ctrl.is_signed) begin
            nxt.acc = in_rec.acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
          end else begin
            nxt.acc = in_rec.ctrl.sub ? '0 : '1;
          end
        end
`endif
      end
    end

    assign stage_d[k] = nxt;
  end

  // Stage registers: bubbles clear only the valid bit so stale data never
  // reaches the outputs; everything holds while the pipe is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        if (stage_d[k].ctrl.valid) begin
          stage_q[k] <= stage_d[k];
        end else begin
          stage_q[k].ctrl.valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid = stage_q[STAGES-1].ctrl.valid;
  assign sum       = stage_q[STAGES-1].acc;
  assign cout      = stage_q[STAGES-1].ctrl.carry;
  assign ovf       = stage_q[STAGES-1].ctrl.ovf;

endmodule

// File: tb/tb_rd4_pipe_adder.sv
// tb_rd4_pipe_adder: directed and randomised checks of rd4_pipe_adder
// (WIDTH=16, DIGITS_PER_STAGE=2). Honours RD4_SAT_EN for expected sums.
module tb_rd4_pipe_adder;

  localparam int WIDTH  = 16;
  localparam int DPS    = 2;
  localparam int STAGES = WIDTH / (2 * DPS);

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              cin;
  logic              sub;
  logic              is_signed;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic              ovf;

  int vectors;
  int miscompares;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        sgn;
    logic [15:0] sum_wrap;
    logic [15:0] sum_sat;
    logic        cout;
    logic        ovf;
  } dir_vec_t;

  rd4_pipe_adder #(
    .WIDTH            (WIDTH),
    .DIGITS_PER_STAGE (DPS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Integer-arithmetic reference: overflow from the true mathematical result
  function automatic exp_t ref_model(input logic [15:0] a_i, input logic [15:0] b_i,
                                     input logic cin_i, input logic sub_i, input logic sgn_i);
    exp_t        r;
    logic [16:0] raw;
    int          x;
    int          y;
    int          res;
    raw = {1'b0, a_i} + {1'b0, (sub_i ? ~b_i : b_i)} + (sub_i ? 17'd1 : {16'd0, cin_i});
    r.sum  = raw[15:0];
    r.cout = raw[16];
    if (sgn_i) begin
      x = int'($signed(a_i));
      y = int'($signed(b_i));
    end else begin
      x = int'(a_i);
      y = int'(b_i);
    end
    res = sub_i ? (x - y) : (x + y + int'(cin_i));
    if (sgn_i) r.ovf = (res > 32767) || (res < -32768);
    else       r.ovf = (res > 65535) || (res < 0);
`ifdef RD4_SAT_EN
    if (r.ovf) begin
      if (sgn_i) r.sum = (res > 0) ? 16'h7FFF : 16'h8000;
      else       r.sum = (res < 0) ? 16'h0000 : 16'hFFFF;
    end
`endif
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid); end
    vectors++; if (sum !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_sum: got %h, expected 0000", sum); end
    vectors++; if (cout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cout: got %b, expected 0", cout); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ovf: got %b, expected 0", ovf); end
    rst = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_directed();
    dir_vec_t v [8];
    v[0] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, 16'h5556, 16'h5556, 1'b0, 1'b0};
    v[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b1};
    v[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
    v[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
    v[4] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 1'b0, 1'b1};
    v[5] = '{16'h0010, 16'h0010, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
    v[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'hFFFE, 16'hFFFE, 1'b1, 1'b0};
    v[7] = '{16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1, 16'h8001, 16'h7FFF, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] exp_sum;
`ifdef RD4_SAT_EN
      exp_sum = v[i].sum_sat;
`else
      exp_sum = v[i].sum_wrap;
`endif
      a = v[i].a; b = v[i].b; cin = v[i].cin; sub = v[i].sub; is_signed = v[i].sgn;
      in_valid = 1'b1;
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL dir%0d_in_ready: got %b, expected 1", i, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 0; c < STAGES - 1; c++) begin
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL dir%0d_early_valid: got %b, expected 0 at cycle %0d", i, out_valid, c + 1); end
        @(negedge clk);
      end
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL dir%0d_out_valid: got %b, expected 1", i, out_valid); end
      vectors++; if (sum !== exp_sum) begin miscompares++; $display("[TB] FAIL dir%0d_sum: got %h, expected %h", i, sum, exp_sum); end
      vectors++; if (cout !== v[i].cout) begin miscompares++; $display("[TB] FAIL dir%0d_cout: got %b, expected %b", i, cout, v[i].cout); end
      vectors++; if (ovf !== v[i].ovf) begin miscompares++; $display("[TB] FAIL dir%0d_ovf: got %b, expected %b", i, ovf, v[i].ovf); end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    localparam int N = 6;
    exp_t        q [$];
    exp_t        e;
    logic [18:0] held;
    int          sent  = 0;
    int          got   = 0;
    int          stall = 0;
    bit          seen  = 1'b0;
    cin = 1'b0; sub = 1'b0; is_signed = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 60 && got < N; cyc++) begin
      if (!seen && out_valid) begin
        seen  = 1'b1;
        stall = 3;
        held  = {out_valid, sum, cout, ovf};
      end
      out_ready = (stall == 0);
      in_valid  = (sent < N);
      a = 16'(sent * 16'h1357 + 16'h0F0F);
      b = 16'(sent * 16'h2468);
      #1;
      if (stall > 0) begin
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_in_ready_stall: got %b, expected 0", in_ready); end
        vectors++; if ({out_valid, sum, cout, ovf} !== held) begin miscompares++; $display("[TB] FAIL bp_hold: got %h, expected %h", {out_valid, sum, cout, ovf}, held); end
        stall--;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_model(a, b, cin, sub, is_signed));
        sent++;
      end
      if (out_valid && out_ready) begin
        e = (q.size() > 0) ? q.pop_front() : '0;
        vectors++; if ({sum, cout, ovf} !== e) begin miscompares++; $display("[TB] FAIL bp_result%0d: got %h/%b/%b, expected %h/%b/%b", got, sum, cout, ovf, e.sum, e.cout, e.ovf); end
        got++;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    vectors++; if (got != N || q.size() != 0) begin miscompares++; $display("[TB] FAIL bp_count: got %0d results (%0d pending), expected %0d", got, q.size(), N); end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1; cin = 1'b0; sub = 1'b0; is_signed = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      a = 16'(16'h0100 * (i + 1)); b = 16'h0011; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_full: got %b, expected 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_out_valid: got %b, expected 0", out_valid); end
    vectors++; if (sum !== 16'h0000) begin miscompares++; $display("[TB] FAIL mid_sum: got %h, expected 0000", sum); end
    vectors++; if (cout !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_cout: got %b, expected 0", cout); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_ovf: got %b, expected 0", ovf); end
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_in_ready: got %b, expected 1", in_ready); end
    @(negedge clk);
    a = 16'h0A0A; b = 16'h0505; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < STAGES - 1; c++) begin
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_stale_valid: got %b, expected 0 at cycle %0d", out_valid, c + 1); end
      @(negedge clk);
    end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_latency: got %b, expected 1", out_valid); end
    vectors++; if ({sum, cout, ovf} !== {16'h0F10, 1'b0, 1'b0}) begin miscompares++; $display("[TB] FAIL mid_result: got %h/%b/%b, expected 0f10/0/0", sum, cout, ovf); end
    @(negedge clk);
  endtask

  task automatic test_random();
    localparam int N = 10000;
    exp_t q [$];
    exp_t e;
    int   sent    = 0;
    int   got     = 0;
    bit   pending = 1'b0;
    for (int cyc = 0; cyc < 40000 && got < N; cyc++) begin
      if (!pending) begin
        if (sent < N && $urandom_range(3) != 0) begin
          a = 16'($urandom); b = 16'($urandom);
          cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1)); is_signed = 1'($urandom_range(1));
          in_valid = 1'b1;
          pending  = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(3) != 0);
      #1;
      if (in_valid && in_ready) begin
        q.push_back(ref_model(a, b, cin, sub, is_signed));
        sent++;
        pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        e = (q.size() > 0) ? q.pop_front() : '0;
        vectors++; if ({sum, cout, ovf} !== e) begin miscompares++; $display("[TB] FAIL rnd_result%0d: got %h/%b/%b, expected %h/%b/%b", got, sum, cout, ovf, e.sum, e.cout, e.ovf); end
        got++;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    vectors++; if (got != N) begin miscompares++; $display("[TB] FAIL rnd_timeout: got %0d results, expected %0d", got, N); end
  endtask

  // Hard time limit so a hung handshake still ends the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence
  initial begin
    clk = 1'b0; rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; is_signed = 1'b0;
    vectors = 0; miscompares = 0;
    @(negedge clk);
    $display("[TB] starting, STAGES=%0d", STAGES);
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
